// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss-fill controller: state encodings
// and default block geometry.
package cache_fill_fsm_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_OFF_W  = $clog2(BLOCK_WORDS);

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_BUSY = 1'b1
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Up-counter used for the issue and receive word counts of a block fill.
// Synchronous clear has priority over enable.
module fill_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling FSM between a cache and multi-cycle main memory. Streams a
// whole block in one read per cycle, writes each returned word into the
// data array and pulses the tag write alongside the final data write.
module cache_fill_fsm #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = cache_fill_fsm_pkg::BLOCK_WORDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           memory_data_valid,
    input  logic [DATA_W-1:0]              memory_data,
    output logic                           fsm_busy,
    output logic                           memory_read,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [DATA_W-1:0]              fill_data,
    output logic                           write_tag_array
);

    import cache_fill_fsm_pkg::*;

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              cnt_clr;
    logic              issue_en;
    logic              recv_en;
    logic [CNT_W-1:0]  addr_idx;

    fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (issue_en),
        .cnt   (issue_cnt)
    );

    fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (recv_en),
        .cnt   (recv_cnt)
    );

    // State, block base and post-reset ready flag; ready_q keeps every
    // output quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL_IDLE;
            base_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        ready_d          = 1'b1;
        cnt_clr          = 1'b0;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_data        = '0;
        case (state_q)
            FILL_IDLE: begin
                fsm_busy = miss_detected & ready_q;
                if (miss_detected && ready_q) begin
                    base_d  = miss_address & ~OFF_MASK;
                    cnt_clr = 1'b1;
                    state_d = FILL_BUSY;
                end
            end
            FILL_BUSY: begin
                fsm_busy    = 1'b1;
                memory_read = (issue_cnt < CNT_FULL);
                issue_en    = memory_read;
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_data        = memory_data;
                    recv_en          = 1'b1;
                    if (recv_cnt == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = FILL_IDLE;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    // Request address; holds the last word address once all reads are issued.
    always_comb begin
        addr_idx       = (issue_cnt < CNT_FULL) ? issue_cnt : CNT_LAST;
        memory_address = base_q + (ADDR_W'(addr_idx) << 1);
    end

    assign fill_word = recv_cnt[IDX_W-1:0];

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a 4-cycle-latency memory model.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int errors = 0;
    int checks = 0;

    logic        pv [4];
    logic [15:0] pa [4];
    logic        stray;

    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        miss;
        logic [15:0] maddr;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wda;
        logic [2:0]  fw;
        logic        tag;
    } vec_t;

    vec_t vt [14];

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 16'(fsm_busy), 16'h0);
        chk({nm, "_read"}, 16'(memory_read), 16'h0);
        chk({nm, "_addr"}, memory_address, 16'h0);
        chk({nm, "_wda"}, 16'(write_data_array), 16'h0);
        chk({nm, "_fw"}, 16'(fill_word), 16'h0);
        chk({nm, "_fdata"}, fill_data, 16'h0);
        chk({nm, "_tag"}, 16'(write_tag_array), 16'h0);
    endtask

    // Advance one clock; memory model returns each read 4 cycles later.
    task automatic cycle();
        logic        r;
        logic [15:0] a;
        r = memory_read;
        a = memory_address;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = r;
        pa[0] = a;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        end
        memory_data_valid = pv[3] | stray;
        memory_data       = pv[3] ? data_of(pa[3]) : 16'hDEAD;
    endtask

    task automatic start_miss(input logic [15:0] a);
        cycle();
        miss_detected = 1'b1;
        miss_address  = a;
        #2;
        chk("miss_busy", 16'(fsm_busy), 16'h1);
    endtask

    // Run the rest of a fill, checking every read, data write and the tag pulse.
    task automatic finish_fill(input logic [15:0] base);
        int ri   = 0;
        int wi   = 0;
        bit done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            cycle();
            miss_detected = 1'b0;
            #2;
            chk("fill_busy", 16'(fsm_busy), 16'h1);
            if (memory_read) begin
                chk("rd_addr", memory_address, 16'(base + 16'(2 * ri)));
                ri++;
            end
            if (write_data_array) begin
                chk("fill_word", 16'(fill_word), 16'(wi));
                chk("fill_data", fill_data, data_of(16'(base + 16'(2 * wi))));
                wi++;
            end
            if (write_tag_array) begin
                chk("tag_writes", 16'(wi), 16'd8);
                chk("tag_reads", 16'(ri), 16'd8);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout: got no tag pulse expected one within 20 cycles, base %h", base);
        end
    endtask

    initial begin
        int tags;
        int wdas;

        // Single fill from 0x1236; misses to 0x4000 during the fill are ignored.
        vt[0]  = '{1'b1, 16'h1236, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0};
        vt[3]  = '{1'b1, 16'h4000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0};
        vt[4]  = '{1'b1, 16'h4000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0};
        vt[5]  = '{1'b1, 16'h4000, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0};
        vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0};
        vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0};
        vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0};
        vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0};
        vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1};
        vt[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};

        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h1236;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        stray             = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = 16'h0;
        end

        // Reset with a miss pending: all outputs quiet.
        #12;
        chk_zero("reset");
        cycle();
        cycle();
        rst_n         = 1'b1;
        miss_detected = 1'b0;
        #2;
        chk_zero("release");

        for (int r = 0; r < 14; r++) begin
            cycle();
            miss_detected = vt[r].miss;
            miss_address  = vt[r].maddr;
            #2;
            chk($sformatf("v%0d_busy", r), 16'(fsm_busy), 16'(vt[r].busy));
            chk($sformatf("v%0d_read", r), 16'(memory_read), 16'(vt[r].rd));
            if (vt[r].rd)
                chk($sformatf("v%0d_addr", r), memory_address, vt[r].addr);
            chk($sformatf("v%0d_wda", r), 16'(write_data_array), 16'(vt[r].wda));
            if (vt[r].wda) begin
                chk($sformatf("v%0d_fw", r), 16'(fill_word), 16'(vt[r].fw));
                chk($sformatf("v%0d_fdata", r), fill_data,
                    data_of(16'(16'h1230 + 16'(2 * vt[r].fw))));
            end
            chk($sformatf("v%0d_tag", r), 16'(write_tag_array), 16'(vt[r].tag));
        end

        // Back-to-back: miss in the cycle busy would drop starts a new fill.
        start_miss(16'h2004);
        finish_fill(16'h2000);
        start_miss(16'h300A);
        finish_fill(16'h3000);
        cycle();
        #2;
        chk("b2b_idle_busy", 16'(fsm_busy), 16'h0);

        // Reset in cycle 7 of a fill aborts it.
        start_miss(16'h5006);
        for (int c = 1; c < 7; c++) begin
            cycle();
            miss_detected = 1'b0;
        end
        cycle();
        #2;
        rst_n = 1'b0;
        stray = 1'b1;
        #1;
        chk_zero("abort");
        cycle();
        cycle();
        stray = 1'b0;
        rst_n = 1'b1;
        #2;
        chk_zero("abort_release");
        tags = 0;
        wdas = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            #2;
            if (write_tag_array) tags++;
            if (write_data_array) wdas++;
        end
        chk("abort_no_tag", 16'(tags), 16'h0);
        chk("abort_no_wda", 16'(wdas), 16'h0);
        start_miss(16'h5006);
        finish_fill(16'h5000);

        // Stray memory_data_valid in IDLE writes nothing.
        stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            #2;
            chk("stray_wda", 16'(write_data_array), 16'h0);
            chk("stray_tag", 16'(write_tag_array), 16'h0);
            chk("stray_busy", 16'(fsm_busy), 16'h0);
        end
        stray = 1'b0;

        // Block at the top of the address space.
        start_miss(16'hFFF8);
        finish_fill(16'hFFF0);
        cycle();
        #2;
        chk("top_idle_busy", 16'(fsm_busy), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
